// File: rtl/kiemtra_sched.sv
// Round-robin owner of a shared flag-check path: grants one requester, samples the
// reference flag for WIN cycles and reports a registered pass/fail verdict.
module kiemtra_sched #(
  parameter int N_REQ  = 4,
  parameter int WIN    = 8,
  parameter int THRESH = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             fl_ref_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             check_en_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             abort_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIN + 1);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_q, win_d;
  logic [CW-1:0] hi_q, hi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pass_q, pass_d;
  logic          abort_q, abort_d;

  logic [PW-1:0] pick;
  logic [PW-1:0] idxP;
  logic          found;
  int            idx;
  logic [PW-1:0] winPlus1;
  logic [CW-1:0] hiInc;

  // First pending requester at or after the pointer, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    idxP  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idxP = PW'(idx);
      if (!found && req_i[idxP]) begin
        found = 1'b1;
        pick  = idxP;
      end
    end
  end

  assign winPlus1 = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
  assign hiInc    = hi_q + CW'(fl_ref_i);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SAMPLE;
          win_d   = pick;
          hi_d    = '0;
          cnt_d   = '0;
        end
      end
      SAMPLE: begin
        // A withdrawn owner wins over a window that would complete on this edge.
        if (!req_i[win_q]) begin
          state_d = IDLE;
          abort_d = 1'b1;
          ptr_d   = winPlus1;
        end else begin
          hi_d  = hiInc;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIN - 1)) begin
            state_d = DONE;
            pass_d  = (hiInc >= CW'(THRESH));
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = winPlus1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      abort_q <= abort_d;
    end
  end

  assign gnt_o      = (state_q != IDLE) ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_q) : '0;
  assign check_en_o = (state_q == SAMPLE);
  assign done_o     = (state_q == DONE);
  assign busy_o     = (state_q != IDLE);
  assign pass_o     = pass_q;
  assign abort_o    = abort_q;

endmodule

// File: doc/kiemtra_sched.md
Name: kiemtra_sched

Overview:
Round-robin scheduler that shares one flag-check resource among N_REQ requesters. It grants one requester at a time and opens a sampling window of WIN cycles on the reference flag. During the window it counts the cycles where the flag is high, then returns a registered pass/fail verdict with a one-cycle done pulse. It sits in front of the flag-check path and drives its check enable, which is a synchronous enable and never a gated clock.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIN, 8, sampling window length in cycles (1..255)
THRESH, 6, minimum high-sample count for pass (1..WIN)

Ports:
clk_i  in  1  single clock, rising edge
rst_i  in  1  asynchronous reset, active-low
req_i  in  N_REQ  level request per requester; held until done_o or withdrawn
fl_ref_i  in  1  reference flag under check, synchronous to clk_i
gnt_o  out  N_REQ  one-hot grant; all-zero when idle
check_en_o  out  1  high exactly during the sampling window
done_o  out  1  one-cycle pulse, verdict valid
pass_o  out  1  verdict; held until next done_o
abort_o  out  1  one-cycle pulse when the granted requester withdraws
busy_o  out  1  high in SAMPLE and DONE

Behaviour:
- Reset (rst_i=0, async):
  - state=IDLE; all outputs 0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
  - Sample counter and window counter = 0.
- States: IDLE, SAMPLE, DONE.
- IDLE:
  - If req_i is nonzero at edge t, pick the first set bit at or after the pointer, wrapping modulo N_REQ.
  - At t+1: gnt_o = one-hot of the winner, check_en_o=1, busy_o=1, state=SAMPLE, counters cleared.
  - If req_i is zero, stay in IDLE.
- SAMPLE:
  - On each edge with check_en_o=1, the high counter increments if fl_ref_i=1.
  - The window counter increments on every such edge.
  - The window lasts exactly WIN cycles: check_en_o is high from t+1 through t+WIN.
  - After the WIN-th sample, go to DONE. check_en_o=0 in DONE.
- DONE (cycle t+WIN+1):
  - done_o=1, pass_o = (count of high samples, including the final one, >= THRESH), gnt_o still asserted.
  - Next cycle: gnt_o=0, busy_o=0, pointer = winner+1 mod N_REQ, state=IDLE.
- Latency:
  - Request to grant: 1 cycle.
  - Request to done_o: WIN+1 cycles.
  - Minimum gap between consecutive grants: one IDLE cycle.
- Abort:
  - If the granted bit of req_i is 0 on any SAMPLE edge, go to IDLE.
  - Next cycle: abort_o=1, gnt_o=0, check_en_o=0, busy_o=0, no done_o, pass_o unchanged.
  - Pointer = winner+1.
  - Abort takes priority over the window completing on the same edge.
- Requests from non-granted requesters during SAMPLE/DONE are ignored and arbitrated only in IDLE.
- A granted requester that keeps req_i high through DONE is re-eligible. Because the pointer advances, it only wins again if no other requester is pending.
- Counter widths: high counter and window counter are clog2(WIN+1) bits; neither can overflow.
- pass_o is registered and changes only in the cycle done_o=1 (or on reset).
- Reset mid-window: immediate return to IDLE, all outputs 0, pointer 0.
- fl_ref_i is ignored outside SAMPLE.

Test Plan:
1. N_REQ=4, WIN=8, THRESH=6. Reset, then req_i=0001, fl_ref_i=1 constant.
   → gnt_o=0001 one cycle later; check_en_o high 8 cycles; done_o at request+9; pass_o=1.
2. Same setup, fl_ref_i high for exactly 5 of the 8 window cycles.
   → pass_o=0.
   Repeat with 6 high cycles → pass_o=1 (threshold boundary).
3. req_i=1111 held continuously.
   → grant order 0001, 0010, 0100, 1000, 0001; each grant separated by one IDLE cycle; four done_o pulses.
4. req_i=0100, drop bit 2 at window cycle 3.
   → abort_o pulse next cycle; no done_o; check_en_o low; pass_o keeps its previous value.
   → Next req_i=0101 grants 0001, because the pointer wrapped to 3 then 0.
5. Assert rst_i=0 at window cycle 4.
   → gnt_o, check_en_o, busy_o go to 0 asynchronously.
   → After release with req_i=1000, the first grant is 1000; with req_i=1001, it is 0001 (pointer=0).
6. Requester 1 asserts req_i while requester 3 is sampling.
   → No change to gnt_o until requester 3's DONE; requester 1 is granted after one IDLE cycle.
